// File: rtl/level_ctrl.sv
// level_ctrl: level sequencer with per-frame fade; optional skip button under LEVEL_CTRL_SKIP_EN
module level_ctrl #(
  parameter int DOOR_X_MIN  = 726,
  parameter int DOOR_X_MAX  = 774,
  parameter int DOOR_Y_MIN  = 426,
  parameter int DOOR_Y_MAX  = 500,
  parameter int FADE_FRAMES = 2,
  parameter int NUM_LEVELS  = 2
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        start_btn,
  input  logic [11:0] player_x,
  input  logic [11:0] player_y,
  input  logic        player_valid,
`ifdef LEVEL_CTRL_SKIP_EN
  input  logic        skip_btn,
`endif
  output logic [1:0]  level_sel,
  output logic [3:0]  fade,
  output logic        level_active,
  output logic        game_done
);
  typedef enum logic [2:0] {S_IDLE, S_FADE_IN, S_PLAY, S_FADE_OUT, S_LOAD, S_DONE} state_t;
  localparam int FW = FADE_FRAMES > 1 ? $clog2(FADE_FRAMES) : 1;
  localparam logic [FW-1:0] CNT_LAST = FW'(FADE_FRAMES - 1);
  localparam logic [1:0] LVL_LAST = 2'(NUM_LEVELS - 1);
  localparam logic [11:0] X_MIN = 12'(DOOR_X_MIN);
  localparam logic [11:0] X_MAX = 12'(DOOR_X_MAX);
  localparam logic [11:0] Y_MIN = 12'(DOOR_Y_MIN);
  localparam logic [11:0] Y_MAX = 12'(DOOR_Y_MAX);
  state_t r_state, w_state;
  logic [1:0] r_level, w_level;
  logic [3:0] r_fade, w_fade;
  logic [FW-1:0] r_cnt, w_cnt;
  logic r_active, w_active, r_done, w_done, r_vblnk_q;
  logic w_tick, w_last, w_door, w_trig;
  assign w_tick = vblnk & ~r_vblnk_q;
  assign w_last = r_cnt == CNT_LAST;
  assign w_door = player_valid & (player_x >= X_MIN) & (player_x <= X_MAX)
                & (player_y >= Y_MIN) & (player_y <= Y_MAX);
`ifdef LEVEL_CTRL_SKIP_EN
  assign w_trig = w_door | skip_btn;
`else
  assign w_trig = w_door;
`endif
  assign level_sel    = r_level;
  assign fade         = r_fade;
  assign level_active = r_active;
  assign game_done    = r_done;
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_level   <= '0;
      r_fade    <= 4'd15;
      r_cnt     <= '0;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
      r_vblnk_q <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_level   <= w_level;
      r_fade    <= w_fade;
      r_cnt     <= w_cnt;
      r_active  <= w_active;
      r_done    <= w_done;
      r_vblnk_q <= vblnk;
    end
  end
  // next state; fades step once every FADE_FRAMES ticks and saturate at 0/15
  always_comb begin
    w_state  = r_state;
    w_level  = r_level;
    w_fade   = r_fade;
    w_cnt    = r_cnt;
    w_active = r_active;
    w_done   = r_done;
    case (r_state)
      S_IDLE: if (start_btn) begin
        w_state = S_FADE_IN;
        w_level = '0;
        w_cnt   = '0;
      end
      S_FADE_IN: if (w_tick) begin
        w_cnt = w_last ? '0 : r_cnt + 1'b1;
        if (w_last) begin
          w_fade = (r_fade == 4'd0) ? 4'd0 : r_fade - 4'd1;
          if (r_fade <= 4'd1) begin
            w_state  = S_PLAY;
            w_active = 1'b1;
          end
        end
      end
      S_PLAY: if (w_tick & w_trig) begin
        w_state  = S_FADE_OUT;
        w_active = 1'b0;
        w_cnt    = '0;
      end
      S_FADE_OUT: if (w_tick) begin
        w_cnt = w_last ? '0 : r_cnt + 1'b1;
        if (w_last) begin
          w_fade = (r_fade == 4'd15) ? 4'd15 : r_fade + 4'd1;
          if (r_fade >= 4'd14) w_state = S_LOAD;
        end
      end
      S_LOAD: if (r_level == LVL_LAST) begin
        w_state = S_DONE;
        w_done  = 1'b1;
        w_fade  = 4'd15;
      end else begin
        w_state = S_FADE_IN;
        w_level = r_level + 2'd1;
        w_cnt   = '0;
      end
      S_DONE: if (start_btn) begin
        w_state = S_IDLE;
        w_level = '0;
        w_done  = 1'b0;
        w_fade  = 4'd15;
      end
      default: w_state = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_level_ctrl.sv
// tb_level_ctrl: directed checks of the level sequencer
module tb_level_ctrl;
  logic clk = 1'b0;
  logic rst, vblnk, start_btn, player_valid;
  logic [11:0] player_x, player_y;
  logic [1:0] level_sel;
  logic [3:0] fade;
  logic level_active, game_done;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  level_ctrl dut (
    .clk(clk),
    .rst(rst),
    .vblnk(vblnk),
    .start_btn(start_btn),
    .player_x(player_x),
    .player_y(player_y),
    .player_valid(player_valid),
`ifdef LEVEL_CTRL_SKIP_EN
    .skip_btn(1'b0),
`endif
    .level_sel(level_sel),
    .fade(fade),
    .level_active(level_active),
    .game_done(game_done)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk) vblnk = 1'b1;
      @(negedge clk) vblnk = 1'b0;
    end
  endtask
  task automatic press_start();
    @(negedge clk) start_btn = 1'b1;
    @(negedge clk) start_btn = 1'b0;
  endtask
  task automatic set_pos(input int x, input int y, input logic v);
    player_x = 12'(x);
    player_y = 12'(y);
    player_valid = v;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_level"}, level_sel, 0);
    chk({tag, "_fade"}, fade, 15);
    chk({tag, "_active"}, level_active, 0);
    chk({tag, "_done"}, game_done, 0);
  endtask
  initial begin
    rst = 1'b1; vblnk = 1'b0; start_btn = 1'b0;
    set_pos(0, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset("reset");
    for (int i = 0; i < 3; i++) begin
      ticks(1);
      chk_reset("idle");
    end
    press_start();
    ticks(1);  chk("fi_t1", fade, 15);
    ticks(1);  chk("fi_t2", fade, 14);
    ticks(27); chk("fi_t29", fade, 1); chk("fi_t29_act", level_active, 0);
    ticks(1);  chk("fi_t30", fade, 0); chk("fi_t30_act", level_active, 1);
    set_pos(725, 450, 1'b1); ticks(5);
    chk("x_out_fade", fade, 0); chk("x_out_act", level_active, 1);
    set_pos(750, 425, 1'b1); ticks(5);
    chk("y_out_fade", fade, 0); chk("y_out_act", level_active, 1);
    set_pos(750, 450, 1'b0); ticks(3);
    chk("invalid_act", level_active, 1);
    press_start();
    chk("play_start_act", level_active, 1); chk("play_start_lvl", level_sel, 0);
    set_pos(750, 450, 1'b1); ticks(1);
    chk("door_act", level_active, 0); chk("door_fade", fade, 0);
    ticks(2);  chk("fo_t2", fade, 1);
    ticks(28); chk("fo_t30", fade, 15); chk("fo_t30_lvl", level_sel, 0);
    @(negedge clk);
    chk("load_lvl", level_sel, 1); chk("load_fade", fade, 15);
    ticks(30);
    chk("l1_fade", fade, 0); chk("l1_entry_act", level_active, 1);
    ticks(1);  chk("l1_door_act", level_active, 0);
    ticks(30); chk("l1_fo_fade", fade, 15); chk("l1_fo_done", game_done, 0);
    @(negedge clk);
    chk("done", game_done, 1); chk("done_lvl", level_sel, 1);
    chk("done_fade", fade, 15); chk("done_act", level_active, 0);
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    chk("restart_lvl", level_sel, 0); chk("restart_done", game_done, 0);
    chk("restart_fade", fade, 15);
    set_pos(0, 0, 1'b0);
    press_start();
    ticks(30);
    set_pos(750, 450, 1'b1);
    ticks(31);
    @(negedge clk);
    chk("g2_lvl", level_sel, 1);
    set_pos(0, 0, 1'b0);
    ticks(30); chk("g2_play", level_active, 1);
    set_pos(774, 500, 1'b1);
    ticks(15); chk("g2_fade7", fade, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("midrst");
    vblnk = 1'b1;
    press_start();
    repeat (10) @(negedge clk);
    chk("hold_fade", fade, 15);
    vblnk = 1'b0;
    ticks(1); chk("hold_t1", fade, 15);
    ticks(1); chk("hold_t2", fade, 14);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/level_ctrl.md
Name: level_ctrl

Overview:
- Game-level sequencer for the VGA drawing chain.
- Selects which level background the downstream drawer renders, and drives a per-frame brightness fade between levels.
- Advances to the next level when the player enters the house door region.
- Sits beside the timing generator. It consumes that generator's vblnk plus the player position, and feeds level_sel/fade to the background and mixer stages.

Parameters:
- DOOR_X_MIN, 726, door region left bound (inclusive), pixels
- DOOR_X_MAX, 774, door region right bound (inclusive)
- DOOR_Y_MIN, 426, door region top bound (inclusive)
- DOOR_Y_MAX, 500, door region bottom bound (inclusive)
- FADE_FRAMES, 2, frames per fade step (>=1)
- NUM_LEVELS, 2, number of playable levels (1..4)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- vblnk  in  1  vertical blank from timing generator
- start_btn  in  1  synchronous start/restart request, level-sensitive
- player_x  in  12  player hotspot column
- player_y  in  12  player hotspot row
- player_valid  in  1  player position valid
- level_sel  out  2  current level index (0-based)
- fade  out  4  darkness: 0 = full brightness, 15 = black
- level_active  out  1  high only in PLAY
- game_done  out  1  high only in DONE

Behaviour:
- All outputs are registered. Reset values: level_sel=0, fade=15, level_active=0, game_done=0; FSM=IDLE; frame_cnt=0; vblnk_q=0.
- Frame tick: vblnk & ~vblnk_q (rising edge of blanking), a one-cycle pulse.
- Fade steps and door checks act only on a tick; outputs change on the cycle after the tick.
- FSM states:
  - IDLE: fade=15. If start_btn=1 -> FADE_IN next cycle, with level_sel=0 and frame_cnt=0. No tick is required.
  - FADE_IN: on each tick frame_cnt++. When frame_cnt reaches FADE_FRAMES-1, clear frame_cnt and decrement fade. If fade would reach 0 -> PLAY with fade=0.
  - PLAY: level_active=1. On a tick with player_valid=1 and player_x in [DOOR_X_MIN,DOOR_X_MAX] and player_y in [DOOR_Y_MIN,DOOR_Y_MAX] (all unsigned, inclusive) -> FADE_OUT, with level_active=0 and frame_cnt=0.
  - FADE_OUT: mirror of FADE_IN; fade increments. Reaching 15 -> LOAD.
  - LOAD: one cycle. If level_sel==NUM_LEVELS-1 -> DONE. Otherwise level_sel++ and -> FADE_IN.
  - DONE: game_done=1, fade=15, level_sel held. start_btn=1 -> IDLE next cycle; level_sel=0 and game_done=0 take effect on that entry.
- Full FADE_IN or FADE_OUT duration: 15*FADE_FRAMES ticks.
- start_btn is ignored outside IDLE and DONE.
- fade saturates: never wraps below 0 or above 15.
- player_valid=0 in PLAY: no door detection.
- A door hit exactly on the tick that enters PLAY is not evaluated; the first check is at the next tick.
- rst asserted mid-fade or mid-PLAY returns to the reset values on the next edge. rst has priority over all inputs.
- vblnk held high never produces a second tick; a tick needs a 0->1 transition.

Optional Feature:
- LEVEL_CTRL_SKIP_EN adds input port skip_btn (1 bit).
- With the macro: in PLAY, skip_btn=1 on a tick forces FADE_OUT exactly like a door hit. If both occur on the same tick, a single transition results.
- Without the macro: the port is absent and only the door region triggers FADE_OUT.

Test Plan:
- Reset, then 3 frames with no start -> level_sel=0, fade=15, level_active=0, game_done=0 throughout.
- start_btn pulse in IDLE, FADE_FRAMES=2 -> fade reaches 14 after 2 ticks, 0 after 30 ticks; level_active=1 on the cycle after tick 30.
- PLAY level 0 with player at (750,450), valid=1 -> FADE_OUT; fade=15 after 30 ticks; LOAD; level_sel=1; FADE_IN to 0.
- Player at (725,450) and at (750,425) (just outside the bounds) for 5 ticks -> remains in PLAY, fade=0.
- Last level (level_sel=1) door hit -> after fade out, game_done=1, fade=15. start_btn -> IDLE with level_sel=0 and game_done=0 on the next cycle.
- rst asserted at fade=7 during FADE_OUT -> next cycle all outputs return to their reset values. A start with vblnk held high produces no fade step until vblnk toggles 0->1.
